simd_signed_pipe: RTL and testbench

- Pipelined SIMD sign-manipulation unit for the vector lane.
- Applies one of four modes to every element of a MAX_WIDTH operand partitioned by SEW: conditional negate, absolute value, negate-all, pass.
- Detects the most-negative overflow case per element and optionally saturates it.
- Two-stage valid/ready pipeline with full throughput, backpressure and flush; sits between the operand read stage and the lane ALU.

---
 rtl/simd_signed_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_simd_signed_pipe.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_signed_pipe.sv
// simd_signed_pipe: two-stage SIMD sign-manipulation unit.
// Each SEW-sized element of opA can be conditionally negated, made absolute,
// negated unconditionally or passed through. The negation is split as
// invert (stage 1) plus a per-element segmented increment (stage 2).
// Elements equal to the most-negative value overflow on negation. They are
// flagged on every slice and can optionally saturate to the most-positive value.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. The producer may drop valid at any time. The unit holds result, ovf and
// sew_err stable while out_valid && !out_ready. in_ready depends
// combinationally on out_ready, because there is no skid buffer.
`timescale 1ns/1ps
module simd_signed_pipe #(
    parameter int MIN_WIDTH = 8,
    parameter int MAX_WIDTH = 64,
    parameter int SEW_WIDTH = $clog2(MAX_WIDTH / MIN_WIDTH) + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [SEW_WIDTH-1:0]           sew,
    input  logic [1:0]                     mode,
    input  logic                           sat_en,
    input  logic [MAX_WIDTH-1:0]           opA,
    input  logic [MAX_WIDTH/MIN_WIDTH-1:0] change,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [MAX_WIDTH-1:0]           result,
    output logic [MAX_WIDTH/MIN_WIDTH-1:0] ovf,
    output logic                           sew_err
);

    localparam int RATIO = MAX_WIDTH / MIN_WIDTH;
    localparam int IW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [1:0] MODE_COND = 2'b00;
    localparam logic [1:0] MODE_ABS  = 2'b01;
    localparam logic [1:0] MODE_NEG  = 2'b10;
    localparam logic [1:0] MODE_PASS = 2'b11;

    localparam logic [MIN_WIDTH-1:0] SLICE_MIN = {1'b1, {(MIN_WIDTH-1){1'b0}}};
    localparam logic [MIN_WIDTH-1:0] SLICE_MAX = {1'b0, {(MIN_WIDTH-1){1'b1}}};

    // Handshake
    logic s1_valid;
    logic s2_advance;
    logic s1_advance;
    logic accept;

    assign s2_advance = !out_valid || out_ready;
    assign s1_advance = !s1_valid || s2_advance;
    assign in_ready   = s1_advance;
    assign accept     = in_valid && in_ready && !flush;

    // Decode / stage-1 combinational
    logic                 sew_bad;
    logic [1:0]           mode_eff;
    logic [IW-1:0]        elem_mask;   // slice-index bits that vary inside one element
    logic [IW-1:0]        slice_lsb [RATIO];
    logic [IW-1:0]        slice_msb [RATIO];
    logic [RATIO-1:0]     slice_sign;
    logic [RATIO-1:0]     slice_ok;    // slice matches its part of the min-value pattern
    logic [RATIO-1:0]     slice_neg;
    logic [RATIO-1:0]     elem_is_min;
    logic [MAX_WIDTH-1:0] s1_data_d;
    logic [RATIO-1:0]     s1_cin_d;
    logic [RATIO-1:0]     s1_link_d;   // slice receives carry from the slice below
    logic [RATIO-1:0]     s1_top_d;    // slice holds its element's MSB
    logic [RATIO-1:0]     s1_min_d;

    // Stage-1 registers
    logic [MAX_WIDTH-1:0] s1_data;
    logic [RATIO-1:0]     s1_cin;
    logic [RATIO-1:0]     s1_link;
    logic [RATIO-1:0]     s1_top;
    logic [RATIO-1:0]     s1_min;
    logic                 s1_sat;
    logic                 s1_err;

    // Stage-2 combinational
    logic [MAX_WIDTH-1:0] s2_result_d;
    logic [MIN_WIDTH:0]   slice_sum;
    logic                 cin_sel;
    logic                 carry;

    // Decode element width; an illegal sew falls back to full width in pass mode
    always_comb begin
        sew_bad   = !$onehot(sew);
        mode_eff  = sew_bad ? MODE_PASS : mode;
        elem_mask = IW'(RATIO - 1);
        for (int i = 0; i < SEW_WIDTH; i++) begin
            if (sew[i] && !sew_bad) elem_mask = IW'((RATIO >> i) - 1);
        end
    end

    // Locate the lowest and highest slice of the element owning each slice
    always_comb begin
        for (int s = 0; s < RATIO; s++) begin
            slice_lsb[s] = IW'(s) & ~elem_mask;
            slice_msb[s] = IW'(s) | elem_mask;
        end
    end

    // Per-slice boundary masks, sign bits and min-value pattern match
    always_comb begin
        slice_sign = '0;
        slice_ok   = '0;
        s1_link_d  = '0;
        s1_top_d   = '0;
        for (int s = 0; s < RATIO; s++) begin
            slice_sign[s] = opA[s*MIN_WIDTH + MIN_WIDTH - 1];
            s1_top_d[s]   = (IW'(s) == slice_msb[s]);
            s1_link_d[s]  = (IW'(s) != slice_lsb[s]);
            slice_ok[s]   = s1_top_d[s] ? (opA[s*MIN_WIDTH +: MIN_WIDTH] == SLICE_MIN)
                                        : (opA[s*MIN_WIDTH +: MIN_WIDTH] == '0);
        end
    end

    // Negate decision, inversion, carry-in injection and overflow detection
    always_comb begin
        slice_neg   = '0;
        elem_is_min = '0;
        s1_data_d   = '0;
        s1_cin_d    = '0;
        s1_min_d    = '0;
        for (int s = 0; s < RATIO; s++) begin
            case (mode_eff)
                MODE_COND: slice_neg[s] = change[slice_msb[s]];
                MODE_ABS:  slice_neg[s] = slice_sign[slice_msb[s]];
                MODE_NEG:  slice_neg[s] = 1'b1;
                default:   slice_neg[s] = 1'b0;
            endcase
            elem_is_min[s] = 1'b1;
            for (int t = 0; t < RATIO; t++) begin
                if ((IW'(t) >= slice_lsb[s]) && (IW'(t) <= slice_msb[s]))
                    elem_is_min[s] = elem_is_min[s] & slice_ok[t];
            end
            s1_data_d[s*MIN_WIDTH +: MIN_WIDTH] = slice_neg[s] ? ~opA[s*MIN_WIDTH +: MIN_WIDTH]
                                                               :  opA[s*MIN_WIDTH +: MIN_WIDTH];
            s1_cin_d[s] = slice_neg[s] & ~s1_link_d[s];
            s1_min_d[s] = slice_neg[s] & elem_is_min[s];
        end
    end

    // Stage 1: capture the inverted operand and per-slice control on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_cin   <= '0;
            s1_link  <= '0;
            s1_top   <= '0;
            s1_min   <= '0;
            s1_sat   <= 1'b0;
            s1_err   <= 1'b0;
        end else begin
            if (flush)
                s1_valid <= 1'b0;
            else if (s1_advance)
                s1_valid <= in_valid;
            if (accept) begin
                s1_data <= s1_data_d;
                s1_cin  <= s1_cin_d;
                s1_link <= s1_link_d;
                s1_top  <= s1_top_d;
                s1_min  <= s1_min_d;
                s1_sat  <= sat_en;
                s1_err  <= sew_bad;
            end
        end
    end

    // Segmented increment; the carry chain restarts at each element's low slice
    always_comb begin
        s2_result_d = '0;
        slice_sum   = '0;
        cin_sel     = 1'b0;
        carry       = 1'b0;
        for (int s = 0; s < RATIO; s++) begin
            cin_sel   = s1_link[s] ? carry : s1_cin[s];
            slice_sum = {1'b0, s1_data[s*MIN_WIDTH +: MIN_WIDTH]} + {{MIN_WIDTH{1'b0}}, cin_sel};
            carry     = slice_sum[MIN_WIDTH];
            if (s1_min[s] && s1_sat)
                s2_result_d[s*MIN_WIDTH +: MIN_WIDTH] = s1_top[s] ? SLICE_MAX : '1;
            else
                s2_result_d[s*MIN_WIDTH +: MIN_WIDTH] = slice_sum[MIN_WIDTH-1:0];
        end
    end

    // Stage 2: output register, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= '0;
            sew_err   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result  <= s2_result_d;
                ovf     <= s1_min;
                sew_err <= s1_err;
            end
        end
    end

endmodule

// File: tb/tb_simd_signed_pipe.sv
// Testbench for simd_signed_pipe: directed vectors, backpressure, random
// stream, flush and mid-stream reset, checked against an arithmetic model.
`timescale 1ns/1ps
module tb_simd_signed_pipe;

    localparam int MINW  = 8;
    localparam int MAXW  = 64;
    localparam int RATIO = MAXW / MINW;
    localparam int SEWW  = 4;
    localparam int EW    = MAXW + RATIO + 1;   // {sew_err, ovf, result}
    localparam int CW    = 80;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [SEWW-1:0]   sew = 4'b1000;
    logic [1:0]        mode = 2'b11;
    logic              sat_en = 1'b0;
    logic [MAXW-1:0]   opA = '0;
    logic [RATIO-1:0]  change = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [MAXW-1:0]   result;
    logic [RATIO-1:0]  ovf;
    logic              sew_err;

    int               checks = 0;
    int               failures = 0;
    int               n_out = 0;
    logic [EW-1:0]    exp_q[$];
    logic             use_fixed = 1'b0;
    logic [EW-1:0]    fixed_exp = '0;
    logic             held_valid = 1'b0;
    logic [EW-1:0]    held_val = '0;
    int               sent;
    int               base;
    logic             saw_stall;
    logic             acc;

    // Clock
    always #5 clk = ~clk;

    simd_signed_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sew       (sew),
        .mode      (mode),
        .sat_en    (sat_en),
        .opA       (opA),
        .change    (change),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .sew_err   (sew_err)
    );

    // Reference: each element as a signed integer, negated with wide arithmetic
    function automatic logic [EW-1:0] ref_model(input logic [SEWW-1:0] s, input logic [1:0] m_in,
                                                input logic sat, input logic [MAXW-1:0] a,
                                                input logic [RATIO-1:0] chg);
        int                      w;
        logic                    err;
        logic [1:0]              m;
        logic                    neg;
        logic [MAXW-1:0]         res;
        logic [RATIO-1:0]        ov;
        logic [MAXW+2:0]         raw;
        logic signed [MAXW+2:0]  x, v, maxp, span;
        err = ($countones(s) != 1);
        w = MAXW;
        if (!err)
            for (int i = 0; i < SEWW; i++) if (s[i]) w = MAXW >> i;
        m = err ? 2'b11 : m_in;
        res = '0;
        ov = '0;
        for (int e = 0; e < MAXW / w; e++) begin
            span = 1;
            span = span <<< w;
            raw = ({3'b000, a} >> (e * w)) & (span - 1);
            x = raw;
            if (raw[w-1]) x = x - span;
            case (m)
                2'b00:   neg = chg[(e + 1) * w / MINW - 1];
                2'b01:   neg = (x < 0);
                2'b10:   neg = 1'b1;
                default: neg = 1'b0;
            endcase
            v = neg ? -x : x;
            maxp = (span >>> 1) - 1;
            if (v > maxp) begin
                for (int k = e * w / MINW; k < (e + 1) * w / MINW; k++) ov[k] = 1'b1;
                if (sat) v = maxp;
            end
            res = res | MAXW'((v & (span - 1)) << (e * w));
        end
        return {err, ov, res};
    endfunction

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [SEWW-1:0] s, input logic [1:0] m, input logic sat,
                            input logic [MAXW-1:0] a, input logic [RATIO-1:0] c,
                            input logic [EW-1:0] e);
        sew = s; mode = m; sat_en = sat; opA = a; change = c;
        fixed_exp = e;
        use_fixed = 1'b1;
    endtask

    task automatic rand_beat();
        if ($urandom_range(0, 5) == 0) sew = SEWW'($urandom);
        else sew = SEWW'(1) << $urandom_range(0, SEWW - 1);
        mode = 2'($urandom);
        sat_en = 1'($urandom);
        change = RATIO'($urandom);
        if ($urandom_range(0, 3) == 0) begin
            for (int k = 0; k < RATIO; k++)
                opA[k*MINW +: MINW] = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00;
        end else begin
            opA = {$urandom, $urandom};
        end
        use_fixed = 1'b0;
    endtask

    task automatic drain(input string tag);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        tick();
        check(tag, CW'(exp_q.size()), CW'(0));
    endtask

    // Scoreboard: record accepts, compare outputs, verify stall stability
    always @(negedge clk) begin
        if (rst_n) begin
            if (held_valid)
                check("hold_stable", CW'({out_valid, sew_err, ovf, result}), CW'({1'b1, held_val}));
            held_valid = out_valid && !out_ready && !flush;
            held_val = {sew_err, ovf, result};
            if (out_valid && out_ready) begin
                n_out++;
                check("output_expected", CW'(exp_q.size() != 0), CW'(1'b1));
                if (exp_q.size() != 0)
                    check("result", CW'({sew_err, ovf, result}), CW'(exp_q.pop_front()));
            end
            if (flush)
                exp_q.delete();
            else if (in_valid && in_ready)
                exp_q.push_back(use_fixed ? fixed_exp : ref_model(sew, mode, sat_en, opA, change));
        end else begin
            held_valid = 1'b0;
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    // Directed sequence
    initial begin
        repeat (3) tick();
        check("reset_in_ready", CW'(in_ready), CW'(1'b1));
        check("reset_out_valid", CW'(out_valid), CW'(1'b0));
        check("reset_result", CW'(result), CW'(0));
        check("reset_ovf", CW'(ovf), CW'(0));
        check("reset_sew_err", CW'(sew_err), CW'(1'b0));
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;

        // 8-bit cond-neg with one wrapping min element, plus latency
        set_beat(4'b1000, 2'b00, 1'b0, 64'h05FF_8001_007F_1003, 8'hA5,
                 {1'b0, 8'h20, 64'hFBFF_8001_0081_10FD});
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("latency_cycle1", CW'(out_valid), CW'(1'b0));
        tick();
        check("latency_cycle2", CW'(out_valid), CW'(1'b1));

        // Back-to-back directed beats
        set_beat(4'b0001, 2'b01, 1'b1, 64'h8000_0000_0000_0000, 8'h00,
                 {1'b0, 8'hFF, 64'h7FFF_FFFF_FFFF_FFFF});
        in_valid = 1'b1;
        tick();
        set_beat(4'b0001, 2'b01, 1'b0, 64'h8000_0000_0000_0000, 8'h00,
                 {1'b0, 8'hFF, 64'h8000_0000_0000_0000});
        tick();
        set_beat(4'b0100, 2'b10, 1'b0, 64'h0000_0001_FFFF_8001, 8'h00,
                 {1'b0, 8'h00, 64'h0000_FFFF_0001_7FFF});
        tick();
        set_beat(4'b0010, 2'b00, 1'b1, 64'h8000_0000_0000_0005, 8'h80,
                 {1'b0, 8'hF0, 64'h7FFF_FFFF_0000_0005});
        tick();
        set_beat(4'b1000, 2'b01, 1'b1, 64'h807F_FF01_8000_81FE, 8'h00,
                 {1'b0, 8'h88, 64'h7F7F_0101_7F00_7F02});
        tick();
        set_beat(4'b0110, 2'b10, 1'b0, 64'h0123_4567_89AB_CDEF, 8'hFF,
                 {1'b1, 8'h00, 64'h0123_4567_89AB_CDEF});
        tick();
        set_beat(4'b0000, 2'b01, 1'b1, 64'h8000_0000_0000_0080, 8'hFF,
                 {1'b1, 8'h00, 64'h8000_0000_0000_0080});
        tick();
        in_valid = 1'b0;
        drain("drain_directed");

        // Ten beats with the consumer stalled for cycles 3-6
        base = n_out;
        saw_stall = 1'b0;
        sent = 0;
        rand_beat();
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid = (sent < 10);
            #1;
            if (in_valid && !in_ready) saw_stall = 1'b1;
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                sent++;
                rand_beat();
            end
        end
        in_valid = 1'b0;
        check("bp_stall_seen", CW'(saw_stall), CW'(1'b1));
        check("bp_count", CW'(n_out - base), CW'(10));
        check("bp_queue_empty", CW'(exp_q.size()), CW'(0));

        // Random stream with random backpressure
        for (int c = 0; c < 300; c++) begin
            rand_beat();
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain("drain_random");

        // Flush with both stages full and a beat offered
        out_ready = 1'b0;
        rand_beat();
        in_valid = 1'b1;
        tick();
        rand_beat();
        tick();
        rand_beat();
        check("full_in_ready", CW'(in_ready), CW'(1'b0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", CW'(out_valid), CW'(1'b0));
        check("flush_in_ready", CW'(in_ready), CW'(1'b1));
        base = n_out;
        out_ready = 1'b1;
        repeat (6) tick();
        check("flush_no_emerge", CW'(n_out - base), CW'(0));

        // Reset in the middle of a stream
        for (int c = 0; c < 4; c++) begin
            rand_beat();
            in_valid = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        check("rst_out_valid", CW'(out_valid), CW'(1'b0));
        check("rst_in_ready", CW'(in_ready), CW'(1'b1));
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("post_rst_idle", CW'(out_valid), CW'(1'b0));
        end
        rand_beat();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        drain("drain_post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
